// File: rtl/aes_spi_host.sv
// SPI host that runs a three-frame decrypt transaction with an AES subordinate:
// key frame, ciphertext frame, then a readback frame that captures the plaintext.
module aes_spi_host #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key,
  input  logic [127:0] msg,
  output logic         cs,
  output logic         sclk,
  output logic         sdo,
  input  logic         sdi,
  output logic [127:0] result,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [2:0] {StIdle, StCsSetup, StShift, StCsHold, StGap, StFinish} state_e;

  localparam logic [15:0] DivLast = 16'(CLK_DIV - 1);
  localparam logic [15:0] GapLast = 16'(GAP - 1);

  state_e         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [8:0]     bit_cnt_q, bit_cnt_d;
  logic [1:0]     frame_q, frame_d;
  logic           sclk_q, sclk_d;
  logic [257:0]   tx_q, tx_d;
  logic [127:0]   msg_q, msg_d;
  logic [127:0]   rx_q, rx_d;
  logic [127:0]   result_q, result_d;
  logic           err_q, err_d;
  logic [8:0]     frame_bits;

  assign frame_bits = (frame_q == 2'd0) ? 9'd258 : 9'd128;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      sclk_q    <= 1'b0;
      tx_q      <= '0;
      msg_q     <= '0;
      rx_q      <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      sclk_q    <= sclk_d;
      tx_q      <= tx_d;
      msg_q     <= msg_d;
      rx_q      <= rx_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    sclk_d    = sclk_q;
    tx_d      = tx_q;
    msg_d     = msg_q;
    rx_d      = rx_q;
    result_d  = result_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          err_d = (key_size == 2'b11);
          if (key_size == 2'b11) begin
            state_d = StFinish;
          end else begin
            tx_d      = {key_size, key};
            msg_d     = msg;
            frame_d   = 2'd0;
            bit_cnt_d = '0;
            state_d   = StCsSetup;
          end
        end
      end
      StCsSetup: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 9'd1;
            if (frame_q == 2'd2) rx_d = {rx_q[126:0], sdi};
          end else begin
            sclk_d = 1'b0;
            tx_d   = {tx_q[256:0], 1'b0};
            if (bit_cnt_q == frame_bits) begin
              state_d = StCsHold;
              if (frame_q == 2'd2) result_d = rx_q;
            end
          end
        end
      end
      StCsHold: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          cnt_d     = '0;
          bit_cnt_d = '0;
          if (frame_q == 2'd2) begin
            state_d = StFinish;
          end else begin
            // Readback frame shifts out zeros, so only the ciphertext needs loading.
            tx_d    = (frame_q == 2'd0) ? {msg_q, 130'd0} : '0;
            frame_d = frame_q + 2'd1;
            state_d = StCsSetup;
          end
        end
      end
      StFinish: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign cs     = !(state_q inside {StCsSetup, StShift, StCsHold});
  assign sclk   = sclk_q;
  assign sdo    = cs ? 1'b0 : tx_q[257];
  assign result = result_q;
  assign busy   = state_q inside {StCsSetup, StShift, StCsHold, StGap};
  assign done   = (state_q == StFinish);
  assign err    = err_q;

endmodule
